// File: rtl/matrix_keypad_event_scanner.sv
// Matrix keypad scanner: debounces a press, walks the columns to find the key,
// debounces its release and queues press/release events in a small FWFT FIFO.
`timescale 1ns/1ps
module matrix_keypad_event_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SETTLE_CYC   = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int RELEASE_EVT  = 1,
    parameter int CODE_W       = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ROWS-1:0]               row_data,
    output logic [COLS-1:0]               col_data,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [CODE_W-1:0]             key_code,
    output logic                          key_release,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int DC_W  = $clog2(DEBOUNCE_CYC);
    localparam int SC_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EVT_W = CODE_W + 1;

    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEBOUNCE_CYC - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SETTLE_CYC - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DB_PRESS = 3'd1;
    localparam logic [2:0] SCAN     = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] DB_REL   = 3'd4;

    logic [2:0]        state;
    logic [DC_W-1:0]   dcnt;
    logic [SC_W-1:0]   scnt;
    logic [COL_W-1:0]  col;
    logic [CODE_W-1:0] held_code;
    logic [CODE_W-1:0] scan_code;
    logic              any_low;
    logic              push_req;
    logic [EVT_W-1:0]  push_data;

    assign any_low = ~&row_data;

    // Descending walk so the lowest-index low row wins.
    always_comb begin
        scan_code = '0;
        for (int unsigned r = ROWS; r > 0; r--) begin
            if (!row_data[r-1])
                scan_code = CODE_W'((r - 1) * COLS + 32'(col));
        end
    end

    always_comb begin
        col_data = '0;
        if (state == SCAN || state == HOLD || state == DB_REL)
            col_data = ~(COLS'(1) << col);
    end

    always_comb begin
        push_req  = 1'b0;
        push_data = '0;
        if (state == SCAN && scnt == SC_LAST && any_low) begin
            push_req  = 1'b1;
            push_data = {1'b0, scan_code};
        end else if (state == DB_REL && !any_low && dcnt == DC_LAST && RELEASE_EVT != 0) begin
            push_req  = 1'b1;
            push_data = {1'b1, held_code};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dcnt      <= '0;
            scnt      <= '0;
            col       <= '0;
            held_code <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_low) begin
                        state <= DB_PRESS;
                        dcnt  <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!any_low) begin
                        state <= IDLE;
                    end else if (dcnt == DC_LAST) begin
                        state <= SCAN;
                        col   <= '0;
                        scnt  <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (scnt == SC_LAST) begin
                        scnt <= '0;
                        if (any_low) begin
                            held_code <= scan_code;
                            state     <= HOLD;
                        end else if (col == COL_LAST) begin
                            state <= IDLE;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!any_low) begin
                        state <= DB_REL;
                        dcnt  <= '0;
                    end
                end
                DB_REL: begin
                    if (any_low) begin
                        state <= HOLD;
                    end else if (dcnt == DC_LAST) begin
                        state <= IDLE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [EVT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             do_push;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = key_valid && key_ready;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req && full && !pop;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign key_valid   = (count != '0);
    assign key_code    = key_valid ? mem[rd_ptr][CODE_W-1:0] : '0;
    assign key_release = key_valid ? mem[rd_ptr][CODE_W] : 1'b0;
    assign fifo_count  = count;

endmodule

// File: tb/tb_matrix_keypad_event_scanner.sv
// Directed bench for the keypad scanner: a behavioural 4x4 key matrix drives row_data
// from col_data; popped events are logged on the falling edge and compared to hand values.
`timescale 1ns/1ps
module tb_matrix_keypad_event_scanner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_data, col_data;
    logic       key_valid, key_ready;
    logic [3:0] key_code;
    logic       key_release;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [15:0] keys;

    logic [3:0] row_data2, col_data2;
    logic       key_valid2;
    logic [3:0] key_code2;
    logic       key_release2;
    logic [2:0] fifo_count2;
    logic       overflow2;
    logic [15:0] keys2;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int valid_cyc = 0;
    int ev_q[$];
    int ev_t[$];
    int ev2_q[$];
    int rel_cyc;

    always #5 clk = ~clk;

    // Key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_data[r]  = ~|(keys[r*4 +: 4] & ~col_data);
            row_data2[r] = ~|(keys2[r*4 +: 4] & ~col_data2);
        end
    end

    matrix_keypad_event_scanner #(
        .ROWS(4), .COLS(4), .DEBOUNCE_CYC(16), .SETTLE_CYC(2), .FIFO_DEPTH(4), .RELEASE_EVT(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .row_data(row_data), .col_data(col_data),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_release(key_release), .fifo_count(fifo_count), .overflow(overflow)
    );

    matrix_keypad_event_scanner #(
        .ROWS(4), .COLS(4), .DEBOUNCE_CYC(16), .SETTLE_CYC(2), .FIFO_DEPTH(4), .RELEASE_EVT(0)
    ) u_dut_nrel (
        .clk(clk), .rst_n(rst_n), .row_data(row_data2), .col_data(col_data2),
        .key_valid(key_valid2), .key_ready(1'b1), .key_code(key_code2),
        .key_release(key_release2), .fifo_count(fifo_count2), .overflow(overflow2)
    );

    // Event log: value = release*16 + code, recorded for every accepted head.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (key_valid && key_ready) begin
            ev_q.push_back(int'(key_release) * 16 + int'(key_code));
            ev_t.push_back(cyc);
        end
        if (key_valid2)
            ev2_q.push_back(int'(key_release2) * 16 + int'(key_code2));
        if (key_valid)
            valid_cyc = valid_cyc + 1;
        if (overflow)
            ov_cnt = ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int ev_at(input int idx);
        return (idx < ev_q.size()) ? ev_q[idx] : -1;
    endfunction

    task automatic clear_log();
        ev_q.delete();
        ev_t.delete();
        ev2_q.delete();
        ov_cnt = 0;
        valid_cyc = 0;
    endtask

    task automatic press_release(input int k);
        keys[k] = 1'b1;
        step(30);
        keys[k] = 1'b0;
        step(30);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_col_data"}, 32'(col_data), 0);
        check({pfx, "_key_valid"}, 32'(key_valid), 0);
        check({pfx, "_key_code"}, 32'(key_code), 0);
        check({pfx, "_key_release"}, 32'(key_release), 0);
        check({pfx, "_fifo_count"}, 32'(fifo_count), 0);
        check({pfx, "_overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        keys = '0;
        keys2 = '0;
        key_ready = 1'b1;
        step(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step(2);

        // Single key row2/col1 held then released.
        clear_log();
        keys[9] = 1'b1;
        step(100);
        rel_cyc = cyc;
        keys[9] = 1'b0;
        step(40);
        check("single_count", 32'(ev_q.size()), 2);
        check("single_press", 32'(ev_at(0)), 9);
        check("single_release", 32'(ev_at(1)), 25);
        check("single_rel_delay", 32'(ev_t.size() == 2 && ev_t[1] - rel_cyc >= 16 && ev_t[1] - rel_cyc <= 20), 1);
        check("single_valid_cycles", 32'(valid_cyc), 2);
        check("single_fifo_empty", 32'(fifo_count), 0);

        // Bounce shorter than the debounce window never yields an event.
        clear_log();
        for (int i = 0; i < 6; i++) begin
            keys[0] = 1'b1;
            step(5);
            keys[0] = 1'b0;
            step(5);
        end
        step(30);
        check("bounce_events", 32'(ev_q.size()), 0);
        check("bounce_col_data", 32'(col_data), 0);
        check("bounce_idle", 32'(u_dut.state), 0);
        check("bounce_valid", 32'(key_valid), 0);

        // Fill the FIFO with the consumer stalled, then overflow on key 10's press.
        clear_log();
        key_ready = 1'b0;
        press_release(0);
        press_release(5);
        check("ovf_full_count", 32'(fifo_count), 4);
        check("ovf_none_yet", 32'(ov_cnt), 0);
        keys[10] = 1'b1;
        step(30);
        check("ovf_pulses", 32'(ov_cnt), 1);
        check("ovf_count_held", 32'(fifo_count), 4);
        check("ovf_head_code", 32'(key_code), 0);
        check("ovf_head_rel", 32'(key_release), 0);
        key_ready = 1'b1;
        step(6);
        check("ovf_drain_count", 32'(ev_q.size()), 4);
        check("ovf_ev0", 32'(ev_at(0)), 0);
        check("ovf_ev1", 32'(ev_at(1)), 16);
        check("ovf_ev2", 32'(ev_at(2)), 5);
        check("ovf_ev3", 32'(ev_at(3)), 21);
        check("ovf_drained", 32'(fifo_count), 0);
        keys[10] = 1'b0;
        step(30);
        check("ovf_rel10", 32'(ev_at(4)), 26);
        check("ovf_pulses_end", 32'(ov_cnt), 1);

        // Push into a full FIFO on the very cycle the head is popped.
        clear_log();
        key_ready = 1'b0;
        press_release(0);
        press_release(5);
        check("pp_full", 32'(fifo_count), 4);
        keys[3] = 1'b1;
        step(24);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        check("pp_count", 32'(fifo_count), 4);
        check("pp_overflow", 32'(overflow), 0);
        check("pp_ovf_pulses", 32'(ov_cnt), 0);
        key_ready = 1'b1;
        step(8);
        check("pp_total", 32'(ev_q.size()), 5);
        check("pp_ev0", 32'(ev_at(0)), 0);
        check("pp_ev1", 32'(ev_at(1)), 16);
        check("pp_ev2", 32'(ev_at(2)), 5);
        check("pp_ev3", 32'(ev_at(3)), 21);
        check("pp_ev4", 32'(ev_at(4)), 3);
        keys[3] = 1'b0;
        step(30);
        check("pp_rel3", 32'(ev_at(5)), 19);

        // Reset during debounce with two events queued.
        clear_log();
        key_ready = 1'b0;
        press_release(0);
        check("mrst_queued", 32'(fifo_count), 2);
        keys[5] = 1'b1;
        step(5);
        check("mrst_in_debounce", 32'(u_dut.state), 1);
        rst_n = 1'b0;
        keys[5] = 1'b0;
        step(1);
        check_reset_outputs("mrst");
        rst_n = 1'b1;
        key_ready = 1'b1;
        step(40);
        check("mrst_no_event", 32'(ev_q.size()), 0);
        check("mrst_count", 32'(fifo_count), 0);

        // Press-only configuration.
        clear_log();
        keys2[15] = 1'b1;
        step(30);
        keys2[15] = 1'b0;
        step(40);
        check("nrel_count", 32'(ev2_q.size()), 1);
        check("nrel_code", 32'((ev2_q.size() > 0) ? ev2_q[0] : -1), 15);
        check("nrel_fifo", 32'(fifo_count2), 0);
        check("nrel_overflow", 32'(overflow2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
